muestreador_pb: RTL and testbench

Oversampling front end that sits directly upstream of the low-pass/majority filter stage. It synchronises a serial input bit and samples it at a programmable tick rate. Each group of SAMPLES*OSF consecutive samples is packed into a parallel word. A one-cycle strobe then presents that word to the filter's DataIn/P interface.

---
 rtl/muestreador_pb.sv | 92 +++++++++
 tb/tb_muestreador_pb.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muestreador_pb.sv
// rtl/muestreador_pb.sv - oversampling serial front end packing samples into filter frames
module muestreador_pb #(
  parameter int SAMPLES = 2,
  parameter int OSF     = 8,
  parameter int DIV     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     resync,
  input  logic                     din,
  output logic [SAMPLES*OSF-1:0]   data_out,
  output logic                     p_out,
  output logic [7:0]               frame_cnt
);

  localparam int N  = SAMPLES * OSF;
  localparam int DW = $clog2(DIV) + 1;
  localparam int SW = $clog2(N) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(N - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [DW-1:0] r_div_cnt;
  logic [SW-1:0] r_smp_cnt;
  logic [N-1:0]  r_sh;
  logic [N-1:0]  r_data_out;
  logic          r_p_out;
  logic [7:0]    r_frame_cnt;

  logic          w_tick;
  logic          w_last;
  logic          w_frame_done;
  logic [N-1:0]  w_sh_next;

  // The shift form below also covers a one-sample frame, where there is no sh[N-2:0] slice.
  assign w_tick       = en & (r_div_cnt == DIV_LAST);
  assign w_last       = (r_smp_cnt == SMP_LAST);
  assign w_frame_done = w_tick & w_last & ~resync;
  assign w_sh_next    = (r_sh << 1) | N'(r_sync2);

  // Two-flop synchroniser bringing the asynchronous serial input into the clock domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // Tick divider, sample counter and shift register; resync realigns even while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_smp_cnt <= '0;
      r_sh      <= '0;
    end else if (resync) begin
      r_div_cnt <= '0;
      r_smp_cnt <= '0;
      r_sh      <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_sh      <= w_sh_next;
      r_smp_cnt <= w_last ? '0 : r_smp_cnt + 1'b1;
    end else if (en) begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Frame output: capture the completed word, strobe for one cycle and count frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_out  <= '0;
      r_p_out     <= 1'b0;
      r_frame_cnt <= 8'd0;
    end else begin
      r_p_out <= w_frame_done;
      if (w_frame_done) begin
        r_data_out  <= w_sh_next;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign data_out  = r_data_out;
  assign p_out     = r_p_out;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_muestreador_pb.sv
// tb/tb_muestreador_pb.sv - self-checking bench for muestreador_pb
module tb_muestreador_pb;

  localparam int N0 = 16;
  localparam int N1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, resync = 1'b0, din = 1'b0;
  logic en1 = 1'b0, resync1 = 1'b0, din1 = 1'b0;

  logic [15:0] data_out;
  logic        p_out;
  logic [7:0]  frame_cnt;
  logic [3:0]  data_out1;
  logic        p_out1;
  logic [7:0]  frame_cnt1;

  muestreador_pb dut (
    .clk(clk), .rst(rst), .en(en), .resync(resync), .din(din),
    .data_out(data_out), .p_out(p_out), .frame_cnt(frame_cnt)
  );

  muestreador_pb #(.SAMPLES(1), .OSF(4), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .resync(resync1), .din(din1),
    .data_out(data_out1), .p_out(p_out1), .frame_cnt(frame_cnt1)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: din history, enabled-cycle count, sample accumulator per instance.
  int          m_ec[2];
  logic        m_h0[2];
  logic        m_h1[2];
  logic [15:0] m_acc[2];
  int          m_cnt[2];
  logic [15:0] m_data[2];
  logic        m_p[2];
  logic [7:0]  m_fc[2];

  task automatic model_step(input int id, input logic rr, input logic e, input logic rs,
                            input logic d, input int dv, input int n);
    logic ds;
    if (rr) begin
      m_ec[id] = 0; m_h0[id] = 1'b0; m_h1[id] = 1'b0; m_acc[id] = '0; m_cnt[id] = 0;
      m_data[id] = '0; m_p[id] = 1'b0; m_fc[id] = 8'd0;
      return;
    end
    ds = m_h1[id];
    m_h1[id] = m_h0[id];
    m_h0[id] = d;
    m_p[id] = 1'b0;
    if (rs) begin
      m_ec[id] = 0; m_acc[id] = '0; m_cnt[id] = 0;
    end else if (e) begin
      m_ec[id]++;
      if (m_ec[id] % dv == 0) begin
        m_acc[id] = {m_acc[id][14:0], ds};
        m_cnt[id]++;
        if (m_cnt[id] == n) begin
          m_data[id] = m_acc[id];
          m_p[id]    = 1'b1;
          m_fc[id]   = m_fc[id] + 8'd1;
          m_acc[id]  = '0;
          m_cnt[id]  = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    model_step(0, rst, en, resync, din, 4, N0);
    model_step(1, rst, en1, resync1, din1, 1, N1);
    @(posedge clk);
    #1;
    chk("p_out", 32'(p_out), 32'(m_p[0]));
    chk("data_out", 32'(data_out), 32'(m_data[0]));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fc[0]));
    chk("p_out1", 32'(p_out1), 32'(m_p[1]));
    chk("data_out1", 32'(data_out1), 32'(m_data[1] & 16'h000F));
    chk("frame_cnt1", 32'(frame_cnt1), 32'(m_fc[1]));
  endtask

  task automatic wait_p(input int limit, output int lat);
    lat = -1;
    for (int c = 1; c <= limit; c++) begin
      cyc();
      if (p_out) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) begin
      n_chk++;
      $display("FAIL wait_p: got no strobe expected one within %0d cycles", limit);
    end
  endtask

  typedef struct {
    logic [15:0] pattern;
    int          gap;
    logic [15:0] exp_word;
    int          exp_lat;
  } vec_t;

  vec_t tv[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat, pulses, j, last, cnt;
    logic [15:0] pat;

    tv[0] = '{16'h000C, 0,  16'h000C, 64};
    tv[1] = '{16'h0007, 0,  16'h0007, 64};
    tv[2] = '{16'hFFFF, 37, 16'hFFFF, 101};
    tv[3] = '{16'h000E, 0,  16'h000E, 64};

    model_step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4, N0);
    model_step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1, N1);

    // reset and idle with en low
    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_p", 32'(p_out), 32'h0);
    chk("rst_fc", 32'(frame_cnt), 32'h0);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 200; c++) begin
      din = ~din;
      cyc();
      if (p_out) pulses++;
    end
    chk("idle_pulses", 32'(pulses), 32'd0);
    chk("idle_data", 32'(data_out), 32'h0);
    chk("idle_fc", 32'(frame_cnt), 32'h0);

    // constant ones with default parameters
    din = 1'b1;
    en = 1'b1;
    wait_p(200, lat);
    chk("ones_lat1", 32'(lat), 32'd64);
    chk("ones_data", 32'(data_out), 32'hFFFF);
    chk("ones_fc1", 32'(frame_cnt), 32'd1);
    wait_p(200, lat);
    chk("ones_lat2", 32'(lat), 32'd64);
    chk("ones_fc2", 32'(frame_cnt), 32'd2);

    // pattern frames and enable gap from the vector table
    for (int i = 0; i < 4; i++) begin
      resync = 1'b1;
      cyc();
      resync = 1'b0;
      pat = tv[i].pattern;
      lat = -1;
      for (int c = 1; c <= 300; c++) begin
        j = (c + 5) / 4;
        if (tv[i].gap > 0) din = 1'b1;
        else din = (j >= 1 && j <= 16) ? pat[16 - j] : 1'b0;
        en = !(c > 20 && c <= 20 + tv[i].gap);
        cyc();
        if (p_out) begin
          lat = c;
          break;
        end
      end
      en = 1'b1;
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tv[i].exp_lat));
      chk($sformatf("vec%0d_data", i), 32'(data_out), 32'(tv[i].exp_word));
      repeat (20) begin
        din = 1'($urandom_range(0, 1));
        cyc();
      end
      chk($sformatf("vec%0d_hold", i), 32'(data_out), 32'(tv[i].exp_word));
    end

    // resync on the completing tick
    resync = 1'b1;
    cyc();
    resync = 1'b0;
    din = 1'b1;
    en = 1'b1;
    pulses = 0;
    repeat (63) begin
      cyc();
      if (p_out) pulses++;
    end
    resync = 1'b1;
    cyc();
    if (p_out) pulses++;
    resync = 1'b0;
    chk("col_pulses", 32'(pulses), 32'd0);
    chk("col_data", 32'(data_out), 32'h000E);
    chk("col_fc", 32'(frame_cnt), 32'd6);
    wait_p(200, lat);
    chk("col_restart", 32'(lat), 32'd64);
    chk("col_fc2", 32'(frame_cnt), 32'd7);

    // resync at tick 9
    resync = 1'b1;
    cyc();
    resync = 1'b0;
    repeat (35) cyc();
    resync = 1'b1;
    cyc();
    resync = 1'b0;
    wait_p(200, lat);
    chk("t9_restart", 32'(lat), 32'd64);
    chk("t9_data", 32'(data_out), 32'hFFFF);

    // random stimulus against the model
    for (int c = 0; c < 3000; c++) begin
      en = ($urandom_range(0, 9) != 0);
      resync = ($urandom_range(0, 199) == 0);
      din = 1'($urandom_range(0, 1));
      din1 = 1'($urandom_range(0, 1));
      cyc();
    end
    resync = 1'b0;

    // asynchronous reset while the strobe is high
    en = 1'b1;
    din = 1'b1;
    wait_p(300, lat);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_p", 32'(p_out), 32'h0);
    chk("arst_data", 32'(data_out), 32'h0);
    chk("arst_fc", 32'(frame_cnt), 32'h0);
    cyc();
    rst = 1'b0;

    // DIV=1, N=4 instance through a frame counter wrap
    en = 1'b0;
    en1 = 1'b1;
    last = -1;
    cnt = 0;
    for (int c = 1; c <= 1100 && cnt < 256; c++) begin
      din1 = 1'($urandom_range(0, 1));
      cyc();
      if (p_out1) begin
        cnt++;
        if (last >= 0) chk("p1_gap", 32'(c - last), 32'd4);
        else chk("p1_first", 32'(c), 32'd4);
        last = c;
        if (cnt == 255) chk("fc1_255", 32'(frame_cnt1), 32'd255);
        if (cnt == 256) chk("fc1_wrap", 32'(frame_cnt1), 32'd0);
      end
    end
    chk("p1_count", 32'(cnt), 32'd256);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
